// File: rtl/ads_spi_engine_if.sv
// Sequencer-side bus of the ADS125x SPI engine: frame request, TX/RX data and status.
interface ads_spi_engine_if #(
   parameter int MAX_BITS = 32
);
   localparam int NB_W = $clog2(MAX_BITS + 1);

   logic                start;
   logic [NB_W-1:0]     nbits;
   logic [NB_W-1:0]     gap_at;
   logic [MAX_BITS-1:0] wrdat;
   logic [MAX_BITS-1:0] rddat;
   logic                busy;
   logic                done;

   modport master (
      output start, nbits, gap_at, wrdat,
      input  rddat, busy, done
   );

   modport slave (
      input  start, nbits, gap_at, wrdat,
      output rddat, busy, done
   );
endinterface

// File: rtl/ads_spi_engine.sv
// SPI master for ADS125x ADCs: one cs_n-framed transfer of 1..MAX_BITS bits, CPOL=0,
// selectable CPHA, divided SCLK and an optional mid-frame SCLK-low gap.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; cs_n high
// ST_SETUP | cs_n low, sclk low, lead-in before the first SCLK edge
// ST_SHIFT | SCLK running, one bit per 2*DIV clocks
// ST_GAP   | sclk held low after bit gap_at (ADS1256 t6 delay)
// ST_HOLD  | sclk and mosi low, trailing delay before cs_n rises
// ST_FIN   | done pulse, busy drops
module ads_spi_engine #(
   parameter int MAX_BITS = 32,
   parameter int DIV      = 4,
   parameter int CPHA     = 1,
   parameter int CS_HOLD  = 2,
   parameter int GAP_CYC  = 0
) (
   input  logic            clk,
   input  logic            rst,
   ads_spi_engine_if.slave bus,
   output logic            cs_n,
   output logic            sclk,
   output logic            mosi,
   input  logic            miso
);
   localparam int NB_W  = $clog2(MAX_BITS + 1);
   localparam int T_A   = (DIV > CS_HOLD) ? DIV : CS_HOLD;
   localparam int T_MAX = (T_A > GAP_CYC) ? T_A : GAP_CYC;
   localparam int TW    = $clog2(T_MAX + 1);

   localparam logic [TW-1:0]   T_HALF  = TW'(DIV - 1);
   localparam logic [TW-1:0]   T_SETUP = TW'(CS_HOLD);
   localparam logic [TW-1:0]   T_HOLD  = TW'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
   localparam logic [TW-1:0]   T_GAP   = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [NB_W-1:0] NB_MAX  = NB_W'(MAX_BITS);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SETUP, ST_SHIFT, ST_GAP, ST_HOLD, ST_FIN
   } state_t;

   state_t              state_q, state_d;
   logic [TW-1:0]       tmr_q, tmr_d;
   logic [NB_W-1:0]     bit_q, bit_d;
   logic [NB_W-1:0]     nb_q, nb_d;
   logic [NB_W-1:0]     gap_q, gap_d;
   logic [MAX_BITS-1:0] tx_q, tx_d;
   logic [MAX_BITS-1:0] rx_q, rx_d;
   logic [MAX_BITS-1:0] rddat_q, rddat_d;
   logic                cs_n_d, sclk_d, mosi_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [NB_W-1:0]     nb_in;
   logic [NB_W-1:0]     bit_inc;

   assign nb_in   = (bus.nbits > NB_MAX) ? NB_MAX : bus.nbits;
   assign bit_inc = bit_q + 1'b1;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      bit_d   = bit_q;
      nb_d    = nb_q;
      gap_d   = gap_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rddat_d = rddat_q;
      cs_n_d  = cs_n;
      sclk_d  = sclk;
      mosi_d  = mosi;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (nb_in != '0) begin
                  nb_d    = nb_in;
                  gap_d   = bus.gap_at;
                  tx_d    = bus.wrdat;
                  rx_d    = '0;
                  bit_d   = '0;
                  tmr_d   = T_SETUP;
                  cs_n_d  = 1'b0;
                  busy_d  = 1'b1;
                  state_d = ST_SETUP;
                  // CPHA=0 slaves sample on the first rise, so bit 0 must already be out
                  if (CPHA == 0) begin
                     mosi_d = bus.wrdat[MAX_BITS-1];
                     tx_d   = bus.wrdat << 1;
                  end
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_SETUP: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end else begin
               tmr_d   = T_HALF;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end else begin
               tmr_d  = T_HALF;
               sclk_d = ~sclk;
               if (!sclk) begin
                  if (CPHA != 0) begin
                     mosi_d = tx_q[MAX_BITS-1];
                     tx_d   = tx_q << 1;
                  end else begin
                     rx_d = {rx_q[MAX_BITS-2:0], miso};
                  end
               end else begin
                  bit_d = bit_inc;
                  if (CPHA != 0) begin
                     rx_d = {rx_q[MAX_BITS-2:0], miso};
                  end else if (bit_inc != nb_q) begin
                     mosi_d = tx_q[MAX_BITS-1];
                     tx_d   = tx_q << 1;
                  end
                  // bit count only rises, so the gap compare can match at most once
                  if (bit_inc == nb_q) begin
                     tmr_d   = T_HOLD;
                     mosi_d  = 1'b0;
                     state_d = ST_HOLD;
                  end else if (GAP_CYC > 0 && bit_inc == gap_q) begin
                     tmr_d   = T_GAP;
                     state_d = ST_GAP;
                  end
               end
            end
         end
         ST_GAP: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end else begin
               tmr_d   = T_HALF;
               state_d = ST_SHIFT;
            end
         end
         ST_HOLD: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end else begin
               cs_n_d  = 1'b1;
               rddat_d = rx_q;
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         bit_q   <= '0;
         nb_q    <= '0;
         gap_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rddat_q <= '0;
         cs_n    <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         bit_q   <= bit_d;
         nb_q    <= nb_d;
         gap_q   <= gap_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rddat_q <= rddat_d;
         cs_n    <= cs_n_d;
         sclk    <= sclk_d;
         mosi    <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.rddat = rddat_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_ads_spi_engine.sv
// Bench for ads_spi_engine: two instances (CPHA=1 with gap, CPHA=0 without) driven by
// directed and random frames, checked against a frame-level reference model.
module tb_ads_spi_engine;
   localparam int MB   = 32;
   localparam int NB_W = 6;
   localparam int CSH  = 2;
   localparam int DIV0 = 2;
   localparam int DIV1 = 3;
   localparam int GAP0 = 20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ads_spi_engine_if #(.MAX_BITS(MB)) bus0 ();
   ads_spi_engine_if #(.MAX_BITS(MB)) bus1 ();

   logic cs_n0, sclk0, mosi0, miso0;
   logic cs_n1, sclk1, mosi1, miso1;
   logic sel, loop;
   logic slv_miso = 1'b0;

   assign miso0 = loop ? mosi0 : slv_miso;
   assign miso1 = loop ? mosi1 : slv_miso;

   ads_spi_engine #(.MAX_BITS(MB), .DIV(DIV0), .CPHA(1), .CS_HOLD(CSH), .GAP_CYC(GAP0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave),
      .cs_n(cs_n0), .sclk(sclk0), .mosi(mosi0), .miso(miso0)
   );

   ads_spi_engine #(.MAX_BITS(MB), .DIV(DIV1), .CPHA(0), .CS_HOLD(CSH), .GAP_CYC(0)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave),
      .cs_n(cs_n1), .sclk(sclk1), .mosi(mosi1), .miso(miso1)
   );

   logic        cs_n_m, sclk_m, mosi_m, busy_m, done_m, cpha_m;
   logic [31:0] rddat_m;
   assign cs_n_m  = sel ? cs_n1 : cs_n0;
   assign sclk_m  = sel ? sclk1 : sclk0;
   assign mosi_m  = sel ? mosi1 : mosi0;
   assign busy_m  = sel ? bus1.busy : bus0.busy;
   assign done_m  = sel ? bus1.done : bus0.done;
   assign rddat_m = sel ? bus1.rddat : bus0.rddat;
   assign cpha_m  = (sel == 1'b0);

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // pin-level monitor and SPI slave, observing settled values on the falling clk edge
   int          frame_id = 0;
   int          last_id  = 0;
   logic [31:0] slv_word = '0;
   logic [31:0] slv_sr   = '0;
   logic [31:0] mosi_cap = '0;
   int pulses = 0, low_tot = 0, run = 0, max_run = 0;
   int cs_low = 0, busy_cnt = 0, busy_rise = 0, done_cnt = 0;
   logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0;

   always @(negedge clk) begin
      if (frame_id != last_id) begin
         last_id  = frame_id;
         slv_sr   = slv_word;
         mosi_cap = '0;
         pulses = 0; low_tot = 0; run = 0; max_run = 0;
         cs_low = 0; busy_cnt = 0; busy_rise = 0; done_cnt = 0;
      end
      if (!cs_n_m && prev_cs && !cpha_m) begin
         slv_miso = slv_sr[31];
         slv_sr   = slv_sr << 1;
      end
      if (sclk_m && !prev_sclk) begin
         if (pulses >= 1 && run > max_run) max_run = run;
         run      = 0;
         pulses++;
         mosi_cap = {mosi_cap[30:0], mosi_m};
         if (cpha_m) begin
            slv_miso = slv_sr[31];
            slv_sr   = slv_sr << 1;
         end
      end else if (!sclk_m && prev_sclk && !cpha_m) begin
         slv_miso = slv_sr[31];
         slv_sr   = slv_sr << 1;
      end
      if (!sclk_m && !cs_n_m && pulses >= 1) begin
         low_tot++;
         run++;
      end
      if (!cs_n_m) cs_low++;
      if (busy_m) busy_cnt++;
      if (busy_m && !prev_busy) busy_rise++;
      if (done_m) done_cnt++;
      prev_sclk = sclk_m;
      prev_cs   = cs_n_m;
      prev_busy = busy_m;
   end

   logic [31:0] last_rd [2];

   task automatic drive_req(input int s, input int nb, input int ga, input logic [31:0] wd);
      bus0.nbits  = NB_W'(nb);
      bus1.nbits  = NB_W'(nb);
      bus0.gap_at = NB_W'(ga);
      bus1.gap_at = NB_W'(ga);
      bus0.wrdat  = wd;
      bus1.wrdat  = wd;
      bus0.start  = (s == 0);
      bus1.start  = (s == 1);
   endtask

   task automatic run_frame(input int s, input int nb, input int ga, input logic [31:0] wd,
                            input bit lp, input logic [31:0] sw, input int re_at);
      int          n, dv, gap, lat_exp, lat;
      bit          gap_on, got, re_done;
      logic [31:0] rd_exp;
      n       = (nb > MB) ? MB : nb;
      dv      = (s == 0) ? DIV0 : DIV1;
      gap_on  = (s == 0) && (GAP0 > 0) && (ga > 0) && (ga < n);
      gap     = gap_on ? GAP0 : 0;
      lat_exp = (n == 0) ? 1 : 2 + 2 * CSH + 2 * dv * n + gap;
      if (n == 0)  rd_exp = last_rd[s];
      else if (lp) rd_exp = wd >> (32 - n);
      else         rd_exp = 32'(64'(sw) & ((64'd1 << n) - 64'd1));

      @(posedge clk); #1;
      sel      = s[0];
      loop     = lp;
      slv_word = sw << (32 - n);
      drive_req(s, nb, ga, wd);
      frame_id++;

      got = 0; lat = 0; re_done = 0;
      for (int c = 1; c <= 1000 && !got; c++) begin
         @(posedge clk); #1;
         bus0.start = 1'b0;
         bus1.start = 1'b0;
         if (re_at > 0 && !re_done && pulses >= re_at) begin
            if (s == 0) bus0.start = 1'b1;
            else        bus1.start = 1'b1;
            re_done = 1;
         end
         if (done_m) begin
            got = 1;
            lat = c - 1;
         end
      end
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("done_seen", 64'(got), 64'd1);
      chk("latency", 64'(lat), 64'(lat_exp));
      chk("rddat", 64'(rddat_m), 64'(rd_exp));
      chk("sclk_pulses", 64'(pulses), 64'(n));
      chk("done_cnt", 64'(done_cnt), 64'd1);
      chk("busy_cycles", 64'(busy_cnt), 64'((n == 0) ? 0 : lat_exp));
      chk("busy_rises", 64'(busy_rise), 64'((n == 0) ? 0 : 1));
      chk("cs_low_cycles", 64'(cs_low), 64'((n == 0) ? 0 : lat_exp - 1));
      if (n > 0) begin
         chk("mosi_bits", 64'(mosi_cap), 64'(wd >> (32 - n)));
         chk("sclk_low_total", 64'(low_tot), 64'((n - 1) * dv + gap + CSH));
      end
      if (n >= 2) chk("max_low_run", 64'(max_run), 64'(gap_on ? GAP0 + dv : dv));
      last_rd[s] = rd_exp;
   endtask

   task automatic abort_frame();
      @(posedge clk); #1;
      sel  = 1'b0;
      loop = 1'b1;
      drive_req(0, 16, 0, $urandom);
      frame_id++;
      @(posedge clk); #1;
      bus0.start = 1'b0;
      for (int c = 0; c < 500 && pulses < 5; c++) begin
         @(posedge clk); #1;
      end
      chk("abort_reach_bit5", 64'(pulses >= 5), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_cs_n", 64'(cs_n_m), 64'd1);
      chk("abort_sclk", 64'(sclk_m), 64'd0);
      chk("abort_mosi", 64'(mosi_m), 64'd0);
      chk("abort_busy", 64'(busy_m), 64'd0);
      chk("abort_done", 64'(done_m), 64'd0);
      chk("abort_rddat", 64'(rddat_m), 64'd0);
      rst = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_cs_stays", 64'(cs_n_m), 64'd1);
   endtask

   initial begin
      int s, nb, n, ga, re;
      rst  = 1'b1;
      sel  = 1'b0;
      loop = 1'b1;
      drive_req(0, 0, 0, '0);
      bus0.start = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n0", 64'(cs_n0), 64'd1);
      chk("rst_sclk0", 64'(sclk0), 64'd0);
      chk("rst_mosi0", 64'(mosi0), 64'd0);
      chk("rst_busy0", 64'(bus0.busy), 64'd0);
      chk("rst_done0", 64'(bus0.done), 64'd0);
      chk("rst_rddat0", 64'(bus0.rddat), 64'd0);
      chk("rst_cs_n1", 64'(cs_n1), 64'd1);
      chk("rst_sclk1", 64'(sclk1), 64'd0);
      chk("rst_busy1", 64'(bus1.busy), 64'd0);
      chk("rst_rddat1", 64'(bus1.rddat), 64'd0);
      rst = 1'b0;

      run_frame(0, 8, 0, 32'h5000_0000, 1'b1, '0, 0);
      run_frame(0, 24, 8, $urandom, 1'b0, 32'h00AB_CDEF, 0);
      chk("gap_low_run", 64'(max_run), 64'(GAP0 + DIV0));
      chk("cmd_rddat16", 64'(rddat_m[15:0]), 64'h0000_CDEF);
      run_frame(0, 0, 0, $urandom, 1'b1, '0, 0);
      run_frame(1, 16, 0, $urandom, 1'b1, '0, 3);
      run_frame(0, 16, 0, $urandom, 1'b1, '0, 3);
      abort_frame();
      run_frame(0, 8, 0, 32'hA500_0000, 1'b1, '0, 0);
      run_frame(1, 32, 0, 32'hA5A5_A5A5, 1'b1, '0, 0);
      run_frame(1, 40, 0, $urandom, 1'b1, '0, 0);

      for (int i = 0; i < 30; i++) begin
         s  = int'($urandom_range(0, 1));
         nb = int'($urandom_range(0, 40));
         n  = (nb > MB) ? MB : nb;
         ga = int'($urandom_range(0, n + 2));
         re = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
         run_frame(s, nb, ga, $urandom, 1'($urandom_range(0, 1)), $urandom, re);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
